// File: rtl/aes_ctrl_pkg.sv
// Shared control definitions for the byte-serial masked AES core.
// Holds job sizes, the scheduler state encoding, the S-box source encoding
// and the tag record that follows each byte through the S-box pipeline.
package aes_ctrl_pkg;

  localparam int unsigned N_STATE_BYTES = 16;
  localparam int unsigned N_KEY_BYTES   = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} sched_state_e;

  typedef enum logic {SRC_STATE = 1'b0, SRC_KEY = 1'b1} sbox_src_e;

  typedef struct packed {
    logic       vld;
    logic       sel;
    logic [3:0] idx;
    logic       last;
  } sbox_tag_t;

  // Index of the final byte of a job for the given source.
  function automatic logic [3:0] last_idx(input logic sel);
    return (sel == SRC_KEY) ? 4'(N_KEY_BYTES - 1) : 4'(N_STATE_BYTES - 1);
  endfunction

endpackage

// File: rtl/sbox_tag_pipe.sv
// Tag shift register that mirrors the masked S-box latency.
// A tag entering on tag_in appears on tag_out SBOX_LAT cycles later.
// Ports:
//   clk       - clock
//   clr       - synchronous clear of every stage
//   tag_in    - tag of the byte issued this cycle (all zero when none)
//   tag_out   - tag of the S-box output valid this cycle
//   any_valid - at least one stage holds a valid tag
module sbox_tag_pipe
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned SBOX_LAT = 4
) (
  input  logic      clk,
  input  logic      clr,
  input  sbox_tag_t tag_in,
  output sbox_tag_t tag_out,
  output logic      any_valid
);

  sbox_tag_t stage [SBOX_LAT];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < SBOX_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int unsigned i = 1; i < SBOX_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[SBOX_LAT-1];

  always_comb begin
    any_valid = 1'b0;
    for (int unsigned i = 0; i < SBOX_LAT; i++) any_valid = any_valid | stage[i].vld;
  end

endmodule

// File: rtl/masked_sbox_scheduler.sv
// Shares the pipelined 2-share masked S-box between the state datapath
// (SubBytes, 16 bytes) and the key schedule (SubWord, 4 bytes).
// Issues one byte per cycle, tags it through the S-box latency, produces
// write-back strobes and done pulses, and gates the PRNG for fresh r.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   ks_req, st_req   - level requests, held until the matching done
//   ks_gnt, st_gnt   - job start pulse, byte 0 issued in the same cycle
//   ks_done, st_done - pulse with the last write-back of the job
//   iss_vld/sel/idx  - byte presented to the S-box (sel 0 state, 1 key)
//   wb_vld/sel/idx   - S-box output valid and its destination
//   prng_en          - advance the randomness source
//   busy             - issuing or any tag in flight
module masked_sbox_scheduler
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned SBOX_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ks_req,
  input  logic       st_req,
  output logic       ks_gnt,
  output logic       st_gnt,
  output logic       ks_done,
  output logic       st_done,
  output logic       iss_vld,
  output logic       iss_sel,
  output logic [3:0] iss_idx,
  output logic       wb_vld,
  output logic       wb_sel,
  output logic [3:0] wb_idx,
  output logic       prng_en,
  output logic       busy
);

  sched_state_e state;
  // blk: requester granted and not yet seen low after its done.
  // fly: job granted and its done pulse not yet produced.
  logic      ks_blk, st_blk, ks_fly, st_fly;
  logic      last_iss, arb_en, gnt_key, gnt_st;
  logic      any_valid;
  sbox_tag_t tag_in, tag_out;

  always_comb begin
    last_iss = iss_vld && (iss_idx == last_idx(iss_sel));
    arb_en   = (state != ISSUE) || last_iss;
    gnt_key  = arb_en && ks_req && !ks_blk;
    gnt_st   = arb_en && st_req && !st_blk && !gnt_key;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      iss_vld <= 1'b0;
      iss_sel <= 1'b0;
      iss_idx <= '0;
      ks_gnt  <= 1'b0;
      st_gnt  <= 1'b0;
      ks_blk  <= 1'b0;
      st_blk  <= 1'b0;
      ks_fly  <= 1'b0;
      st_fly  <= 1'b0;
    end else begin
      ks_gnt <= gnt_key;
      st_gnt <= gnt_st;
      if (ks_done) ks_fly <= 1'b0;
      if (st_done) st_fly <= 1'b0;
      if (!ks_req && !ks_fly) ks_blk <= 1'b0;
      if (!st_req && !st_fly) st_blk <= 1'b0;

      if (gnt_key || gnt_st) begin
        state   <= ISSUE;
        iss_vld <= 1'b1;
        iss_sel <= gnt_key ? SRC_KEY : SRC_STATE;
        iss_idx <= '0;
        if (gnt_key) begin
          ks_blk <= 1'b1;
          ks_fly <= 1'b1;
        end else begin
          st_blk <= 1'b1;
          st_fly <= 1'b1;
        end
      end else begin
        unique case (state)
          ISSUE: begin
            if (last_iss) begin
              state   <= DRAIN;
              iss_vld <= 1'b0;
              iss_sel <= 1'b0;
              iss_idx <= '0;
            end else begin
              iss_idx <= iss_idx + 4'd1;
            end
          end
          DRAIN:   if (!any_valid) state <= IDLE;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    tag_in      = '0;
    tag_in.vld  = iss_vld;
    tag_in.sel  = iss_sel;
    tag_in.idx  = iss_idx;
    tag_in.last = last_iss;
  end

  sbox_tag_pipe #(.SBOX_LAT(SBOX_LAT)) u_tag_pipe (
    .clk       (clk),
    .clr       (rst),
    .tag_in    (tag_in),
    .tag_out   (tag_out),
    .any_valid (any_valid)
  );

  assign wb_vld  = tag_out.vld;
  assign wb_sel  = tag_out.sel;
  assign wb_idx  = tag_out.idx;
  assign ks_done = tag_out.vld & tag_out.last & tag_out.sel;
  assign st_done = tag_out.vld & tag_out.last & ~tag_out.sel;
  assign prng_en = iss_vld | any_valid;
  assign busy    = prng_en;

endmodule
